// File: rtl/load_store_unit.sv
// Memory stage: one load/store per transaction, decoding the address to the
// data RAM, the io_out register or the io_in port.
module load_store_unit #(
    parameter int         RAM_DEPTH = 16,
    parameter logic [7:0] IO_BASE   = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_fault,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {RG_RAM, RG_IO_OUT, RG_IO_IN, RG_NONE} region_t;

    localparam logic [7:0] IO_IN_ADDR = 8'(IO_BASE + 8'd1);

    state_t     r_state;
    state_t     w_next;
    region_t    r_region;
    region_t    w_region;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [7:0] r_io_out;
    logic       w_ram_hit;
    logic       w_accept;
    logic       w_fault_dec;
    logic [7:0] w_load_data;
    logic       w_ready;
    logic       w_resp_valid;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_fault;

    // 9-bit compare so RAM_DEPTH=256 still covers the whole byte space
    assign w_ram_hit = ({1'b0, req_addr} < 9'(RAM_DEPTH));
    assign w_accept  = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_region = RG_NONE;
        if (w_ram_hit)
            w_region = RG_RAM;
        else if (req_addr == IO_BASE)
            w_region = RG_IO_OUT;
        else if (req_addr == IO_IN_ADDR)
            w_region = RG_IO_IN;
    end

    assign w_fault_dec = (r_region == RG_NONE) ||
                         ((r_region == RG_IO_IN) && r_we);

    always_comb begin
        w_load_data = 8'h00;
        if (!r_we) begin
            case (r_region)
                RG_RAM:    w_load_data = mem_rdata;
                RG_IO_OUT: w_load_data = r_io_out;
                RG_IO_IN:  w_load_data = io_in;
                default:   w_load_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (req_valid)
                    w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_next = S_RESP;
                if (r_region == RG_RAM) begin
                    w_mem_read  = !r_we;
                    w_mem_write = r_we;
                end
            end
            S_RESP: begin
                w_next       = S_IDLE;
                w_resp_valid = 1'b1;
                w_fault      = w_fault_dec;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_region <= RG_NONE;
            r_rdata  <= 8'h00;
            r_io_out <= 8'h00;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_region <= w_region;
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= w_load_data;
                if (r_we && (r_region == RG_IO_OUT))
                    r_io_out <= r_wdata;
            end
        end
    end

    assign req_ready  = w_ready;
    assign resp_valid = w_resp_valid;
    assign resp_fault = w_fault;
    assign resp_rdata = r_rdata;
    assign mem_read   = w_mem_read;
    assign mem_write  = w_mem_write;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign io_out     = r_io_out;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit
// with a 16-byte RAM model.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_fault;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc;

  logic [7:0] ram [16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        ram[i] <= 8'(8'h10 + i);
    end else if (mem_write) begin
      ram[mem_addr[3:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ?
    ram[mem_addr[3:0]] : 8'h00;

  load_store_unit #(
    .RAM_DEPTH(16),
    .IO_BASE(8'hF0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_in(io_in),
    .io_out(io_out)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic txn(
    input string      tag,
    input logic       we,
    input logic [7:0] addr,
    input logic [7:0] wdata,
    input logic       exp_rd,
    input logic       exp_wr,
    input logic [7:0] exp_rdata,
    input logic       exp_fault
  );
    chk({tag, "/ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "/rd"}, mem_read, exp_rd);
    chk({tag, "/wr"}, mem_write, exp_wr);
    if (exp_rd || exp_wr)
      chk({tag, "/maddr"}, mem_addr, addr);
    if (exp_wr)
      chk({tag, "/mwdata"}, mem_wdata, wdata);
    chk({tag, "/early_rv"}, resp_valid, 1'b0);
    chk({tag, "/busy"}, req_ready, 1'b0);
    @(negedge clk);
    chk({tag, "/rv"}, resp_valid, 1'b1);
    chk({tag, "/fault"}, resp_fault, exp_fault);
    chk({tag, "/rdata"}, resp_rdata, exp_rdata);
    chk({tag, "/rsp_strobe"},
        mem_read | mem_write, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    io_in     = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst/ready", req_ready, 1'b1);
    chk("rst/rv", resp_valid, 1'b0);
    chk("rst/fault", resp_fault, 1'b0);
    chk("rst/rd", mem_read, 1'b0);
    chk("rst/wr", mem_write, 1'b0);
    chk("rst/io_out", io_out, 8'h00);
    chk("rst/rdata", resp_rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    txn("st03", 1'b1, 8'h03, 8'h5A,
        1'b0, 1'b1, 8'h00, 1'b0);
    txn("ld03", 1'b0, 8'h03, 8'h00,
        1'b1, 1'b0, 8'h5A, 1'b0);
    chk("hold_rdata", resp_rdata, 8'h5A);

    txn("ld0F", 1'b0, 8'h0F, 8'h00,
        1'b1, 1'b0, 8'h1F, 1'b0);
    txn("ld10", 1'b0, 8'h10, 8'h00,
        1'b0, 1'b0, 8'h00, 1'b1);
    txn("ld80", 1'b0, 8'h80, 8'h00,
        1'b0, 1'b0, 8'h00, 1'b1);

    txn("stF0", 1'b1, 8'hF0, 8'hC3,
        1'b0, 1'b0, 8'h00, 1'b0);
    chk("io_out_set", io_out, 8'hC3);
    txn("ldF0", 1'b0, 8'hF0, 8'h00,
        1'b0, 1'b0, 8'hC3, 1'b0);
    txn("stF1", 1'b1, 8'hF1, 8'h77,
        1'b0, 1'b0, 8'h00, 1'b1);
    chk("io_out_keep", io_out, 8'hC3);
    txn("stF5", 1'b1, 8'hF5, 8'h12,
        1'b0, 1'b0, 8'h00, 1'b1);
    chk("io_out_keep2", io_out, 8'hC3);

    io_in = 8'h81;
    txn("ldF1", 1'b0, 8'hF1, 8'h00,
        1'b0, 1'b0, 8'h81, 1'b0);

    n_acc     = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h01;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("tput/ready%0d", k),
          req_ready, (k % 3) == 0);
      chk($sformatf("tput/rv%0d", k),
          resp_valid, (k % 3) == 2);
      if (req_ready && req_valid)
        n_acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("tput/accepts", n_acc, 3);
    chk("tput/rdata", resp_rdata, 8'h11);

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h02;
    req_wdata = 8'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstacc/wr", mem_write, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc/ready", req_ready, 1'b1);
    chk("rstacc/rv", resp_valid, 1'b0);
    chk("rstacc/fault", resp_fault, 1'b0);
    chk("rstacc/rd", mem_read, 1'b0);
    chk("rstacc/wr0", mem_write, 1'b0);
    chk("rstacc/maddr", mem_addr, 8'h00);
    chk("rstacc/mwdata", mem_wdata, 8'h00);
    chk("rstacc/rdata", resp_rdata, 8'h00);
    chk("rstacc/io_out", io_out, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstacc/quiet%0d", k),
          {resp_valid, mem_write, mem_read},
          3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
